// File: rtl/ssp_rx_deframer.sv
// ssp_rx_deframer: SSP receive deframer, serial-to-parallel with receive FIFO and APB-style read path.
// Revision 1.0
`default_nettype none

module ssp_rx_deframer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             PCLK,
  input  logic             CLEAR_B,
  input  logic             PSEL,
  input  logic             PWRITE,
  input  logic             SSPCLKIN,
  input  logic             SSPFSSIN,
  input  logic             SSPRXD,
  output logic [WIDTH-1:0] PRDATA,
  output logic             SSPRXINTR,
  output logic             SSPRXOVR
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state, state_nx;
  logic [BW-1:0]     bitcnt, bitcnt_nx;
  logic [WIDTH-1:0]  shreg, shreg_nx;
  logic [WIDTH-1:0]  push_word;
  logic              push;
  logic              sclk_prev;
  logic              sample_en;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, count_nx;
  logic              full, pop, wr_en, ovr_set;

  // Serial data is launched on the rising SSPCLKIN edge, so sample on the falling one.
  assign sample_en = sclk_prev & ~SSPCLKIN;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      sclk_prev <= 1'b0;
    end else begin
      state     <= state_nx;
      bitcnt    <= bitcnt_nx;
      shreg     <= shreg_nx;
      sclk_prev <= SSPCLKIN;
    end
  end

  always_comb begin
    state_nx  = state;
    bitcnt_nx = bitcnt;
    shreg_nx  = shreg;
    push      = 1'b0;
    push_word = {shreg[WIDTH-2:0], SSPRXD};
    case (state)
      IDLE: begin
        if (sample_en && SSPFSSIN) begin
          state_nx  = SHIFT;
          bitcnt_nx = '0;
        end
      end
      SHIFT: begin
        if (sample_en) begin
          shreg_nx  = push_word;
          bitcnt_nx = bitcnt + 1'b1;
          if (bitcnt == BW'(WIDTH - 1)) begin
            push      = 1'b1;
            bitcnt_nx = '0;
            // FSS on the last bit chains straight into the next frame.
            state_nx  = SSPFSSIN ? SHIFT : IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign full    = (count == CW'(DEPTH));
  assign pop     = PSEL & ~PWRITE & (count != '0);
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  always_comb begin
    count_nx = count;
    case ({wr_en, pop})
      2'b10:   count_nx = count + 1'b1;
      2'b01:   count_nx = count - 1'b1;
      default: count_nx = count;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      PRDATA    <= '0;
      SSPRXINTR <= 1'b0;
      SSPRXOVR  <= 1'b0;
    end else begin
      count     <= count_nx;
      SSPRXINTR <= (count_nx == CW'(DEPTH));
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        PRDATA <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (ovr_set) begin
        SSPRXOVR <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ssp_rx_deframer.sv
// tb_ssp_rx_deframer: directed and randomized frames checked against a queue model of the receive FIFO.
// Revision 1.0
`default_nettype none

module tb_ssp_rx_deframer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             PCLK = 1'b0;
  logic             CLEAR_B = 1'b0;
  logic             PSEL = 1'b0;
  logic             PWRITE = 1'b0;
  logic             SSPCLKIN = 1'b0;
  logic             SSPFSSIN = 1'b0;
  logic             SSPRXD = 1'b0;
  logic [WIDTH-1:0] PRDATA;
  logic             SSPRXINTR;
  logic             SSPRXOVR;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_prdata = '0;
  logic             m_ovr = 1'b0;

  ssp_rx_deframer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .SSPCLKIN  (SSPCLKIN),
    .SSPFSSIN  (SSPFSSIN),
    .SSPRXD    (SSPRXD),
    .PRDATA    (PRDATA),
    .SSPRXINTR (SSPRXINTR),
    .SSPRXOVR  (SSPRXOVR)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #500_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".prdata"}, 32'(PRDATA), 32'(m_prdata));
    check({tag, ".intr"}, 32'(SSPRXINTR), 32'(q.size() == DEPTH));
    check({tag, ".ovr"}, 32'(SSPRXOVR), 32'(m_ovr));
  endtask

  // One PCLK cycle; push marks the cycle carrying the last sample of a frame.
  task automatic cyc(input bit sclk, input bit fss, input bit d, input bit psel,
                     input bit pwrite, input bit push, input logic [WIDTH-1:0] w);
    @(negedge PCLK);
    SSPCLKIN = sclk;
    SSPFSSIN = fss;
    SSPRXD   = d;
    PSEL     = psel;
    PWRITE   = pwrite;
    @(posedge PCLK);
    if (psel && !pwrite && q.size() > 0) m_prdata = q.pop_front();
    if (push) begin
      if (q.size() < DEPTH) q.push_back(w);
      else m_ovr = 1'b1;
    end
    #1;
    check_outputs("cyc");
  endtask

  task automatic rnd_rd(input bit en, output bit psel, output bit pwrite);
    psel   = en && ($urandom_range(0, 3) == 0);
    pwrite = psel && ($urandom_range(0, 1) == 1);
  endtask

  // lead: send FSS period first; chain: FSS on last bit; rd_last: read on the 8th sample edge.
  task automatic send_frame(input logic [WIDTH-1:0] w, input bit lead, input bit chain,
                            input bit rd_last, input bit rd_rand);
    bit ps, pw, fb;
    logic [WIDTH-1:0] wv;
    wv = w;
    if (lead) begin
      rnd_rd(rd_rand, ps, pw);
      cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), ps, pw, 1'b0, '0);
      rnd_rd(rd_rand, ps, pw);
      cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)), ps, pw, 1'b0, '0);
    end
    for (int i = WIDTH - 1; i >= 0; i--) begin
      fb = (i == 0) && chain;
      rnd_rd(rd_rand, ps, pw);
      cyc(1'b1, fb, wv[i], ps, pw, 1'b0, '0);
      rnd_rd(rd_rand, ps, pw);
      if (i == 0 && rd_last) begin
        ps = 1'b1;
        pw = 1'b0;
      end
      cyc(1'b0, fb, wv[i], ps, pw, (i == 0), wv);
    end
  endtask

  task automatic rd(input bit pwrite);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, pwrite, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    CLEAR_B  = 1'b0;
    SSPCLKIN = 1'b0;
    SSPFSSIN = 1'b0;
    PSEL     = 1'b0;
    PWRITE   = 1'b0;
    #1;
    check("rst.prdata", 32'(PRDATA), 32'h0);
    check("rst.intr", 32'(SSPRXINTR), 32'h0);
    check("rst.ovr", 32'(SSPRXOVR), 32'h0);
    q.delete();
    m_prdata = '0;
    m_ovr    = 1'b0;
    repeat (2) @(negedge PCLK);
    check("rst_hold.prdata", 32'(PRDATA), 32'h0);
    check("rst_hold.ovr", 32'(SSPRXOVR), 32'h0);
    CLEAR_B = 1'b1;
  endtask

  initial begin
    bit chained;
    logic [WIDTH-1:0] tail;
    do_reset();

    // Single frame
    send_frame(8'h35, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rd(1'b0);
    check("single", 32'(PRDATA), 32'h35);

    // Back-to-back frames, third read on an empty FIFO
    send_frame(8'hAE, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h26, 1'b0, 1'b0, 1'b0, 1'b0);
    rd(1'b0);
    check("b2b0", 32'(PRDATA), 32'hAE);
    rd(1'b0);
    rd(1'b0);
    check("b2b_empty", 32'(PRDATA), 32'h26);

    // Write cycles ignored
    send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(1'b1);
    rd(1'b1);
    rd(1'b0);
    check("wr_ign", 32'(PRDATA), 32'h55);
    rd(1'b0);

    // Full with simultaneous pop on the 8th sample edge
    for (int i = 0; i < DEPTH; i++) send_frame(WIDTH'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    check("full.intr", 32'(SSPRXINTR), 32'h1);
    send_frame(8'hB6, 1'b1, 1'b0, 1'b1, 1'b0);
    check("simul.ovr", 32'(SSPRXOVR), 32'h0);
    check("simul.intr", 32'(SSPRXINTR), 32'h1);
    for (int i = 0; i < DEPTH; i++) rd(1'b0);
    check("simul.last", 32'(PRDATA), 32'hB6);

    // Reset mid-frame
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 7; i >= 4; i--) begin
      tail = 8'hF3;
      cyc(1'b1, 1'b0, tail[i], 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, tail[i], 1'b0, 1'b0, 1'b0, '0);
    end
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
    end
    send_frame(8'h84, 1'b1, 1'b0, 1'b0, 1'b0);
    rd(1'b0);
    check("after_rst", 32'(PRDATA), 32'h84);
    rd(1'b0);
    check("after_rst_empty", 32'(PRDATA), 32'h84);

    // Fill and overrun
    send_frame(8'h94, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h51, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(8'h24, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fill.intr", 32'(SSPRXINTR), 32'h1);
    check("fill.ovr", 32'(SSPRXOVR), 32'h0);
    send_frame(8'h67, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovr.set", 32'(SSPRXOVR), 32'h1);
    rd(1'b0);
    check("ovr.rd0", 32'(PRDATA), 32'h94);
    check("ovr.intr_fall", 32'(SSPRXINTR), 32'h0);
    rd(1'b0);
    rd(1'b0);
    rd(1'b0);
    check("ovr.rd3", 32'(PRDATA), 32'h24);
    rd(1'b0);
    check("ovr.sticky", 32'(SSPRXOVR), 32'h1);

    // Randomized traffic
    do_reset();
    chained = 1'b0;
    for (int k = 0; k < 250; k++) begin
      int op;
      bit ps, pw;
      op = chained ? 0 : int'($urandom_range(0, 5));
      if (op <= 2) begin
        bit ch;
        ch = ($urandom_range(0, 2) == 0);
        send_frame(WIDTH'($urandom), !chained, ch, ($urandom_range(0, 7) == 0), 1'b1);
        chained = ch;
      end else if (op == 3) begin
        cyc(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
      end else begin
        rnd_rd(1'b1, ps, pw);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, pw, 1'b0, '0);
      end
    end
    while (q.size() > 0) rd(1'b0);
    rd(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ssp_rx_deframer.md
Name: ssp_rx_deframer

Overview:
- Receive half of the SSP serial link. Samples the looped-back or external serial clock, frame-sync and data lines, and deserializes 8-bit MSB-first frames.
- Buffers received words in a small FIFO and returns them on the APB-style read path (PSEL & !PWRITE).
- Counterpart of the SSP transmit logic: consumes exactly the SSPCLKOUT/SSPFSSOUT/SSPTXD format that the transmit logic produces.

Parameters:
- WIDTH, 8, bits per frame and FIFO word width.
- DEPTH, 4, receive FIFO entries; power of two, at least 2.

Ports:
- PCLK  input  1  system clock; all logic on rising edge.
- CLEAR_B  input  1  asynchronous active-low reset.
- PSEL  input  1  peripheral select.
- PWRITE  input  1  1 = write cycle (ignored by this block), 0 = read cycle.
- SSPCLKIN  input  1  serial clock, PCLK/2, synchronous to PCLK.
- SSPFSSIN  input  1  frame sync, high for one SSPCLKIN period before the MSB.
- SSPRXD  input  1  serial data, MSB first.
- PRDATA  output  WIDTH  read data, registered.
- SSPRXINTR  output  1  high while the FIFO is full.
- SSPRXOVR  output  1  sticky overrun flag.

Behaviour:
- Reset (CLEAR_B=0, asynchronous): PRDATA=0, SSPRXINTR=0, SSPRXOVR=0, FIFO empty, state IDLE, bit counter 0, shift register 0, sclk_prev=0.
- Sample edge: registered sclk_prev; sample_en = sclk_prev & !SSPCLKIN (falling edge of SSPCLKIN). SSPFSSIN and SSPRXD are captured only in a cycle with sample_en=1.
- FSM IDLE:
  - On sample_en with SSPFSSIN=1: go to SHIFT, bitcnt=0.
  - Otherwise stay in IDLE. SSPRXD is ignored.
- FSM SHIFT:
  - On each sample_en: shreg = {shreg[WIDTH-2:0], SSPRXD}, bitcnt++.
  - On the sample_en where bitcnt==WIDTH-1 (the 8th bit), push the completed word {shreg[WIDTH-2:0], SSPRXD}.
  - After that 8th bit: if SSPFSSIN=1 in the same sample, stay in SHIFT with bitcnt=0 (back-to-back frame, no gap). Otherwise go to IDLE.
  - SSPFSSIN is ignored on bits 1..7.
- Push latency: the word is visible in the FIFO the cycle after the 8th sample edge. The earliest it can appear on PRDATA is one cycle later, via a read.
- Read: on posedge with PSEL=1, PWRITE=0 and FIFO not empty, PRDATA <= head and the head is popped.
  - Read with FIFO empty: PRDATA holds its value, no pointer change, no error.
  - PSEL=1, PWRITE=1: no effect.
- Simultaneous push and pop:
  - Both happen; count is unchanged.
  - This is allowed when full, because the pop frees a slot in the same cycle, so no overrun.
- Push when full without a same-cycle pop: the word is dropped, FIFO contents are unchanged, and SSPRXOVR <= 1. SSPRXOVR clears only on reset.
- SSPRXINTR = (count == DEPTH), registered with the count, so it updates in the same cycle as the count.
- Pointers: wrap modulo DEPTH. count is held in $clog2(DEPTH)+1 bits.
- Reset mid-frame: the partial word is discarded, and the next frame needs a fresh SSPFSSIN pulse.
- FSS glitch in IDLE coinciding with sample_en, but with no following data: the FSM still shifts 8 samples. Framing is FSS-driven only.

Test Plan:
- Single frame: FSS pulse, then serial 0x35 MSB-first at PCLK/2, then PSEL=1, PWRITE=0 for one cycle -> PRDATA=0x35, SSPRXINTR=0, SSPRXOVR=0.
- Back-to-back frames: 0xAE then 0x26 with FSS high on the last bit of 0xAE, then two reads -> PRDATA=0xAE then 0x26; a third read leaves PRDATA=0x26.
- Fill: frames 0x94, 0x0F, 0x51, 0x24 with no reads -> SSPRXINTR=1 after the 4th push. A 5th frame 0x67 -> SSPRXOVR=1, and reads return 0x94, 0x0F, 0x51, 0x24 (0x67 dropped). SSPRXINTR falls after the first read.
- Full with simultaneous pop: FIFO full, a read asserted in the same cycle as the 8th sample edge of frame 0xB6 -> no overrun, SSPRXINTR stays 1, last read returns 0xB6.
- Reset mid-frame: CLEAR_B low after 4 bits of 0xF3, release, then send frame 0x84 -> only 0x84 is read, and every output shows its reset value while CLEAR_B=0.
- Write cycles ignored: PSEL=1, PWRITE=1 with FIFO holding 0x55 -> PRDATA and count unchanged; a subsequent read returns 0x55.
